exp_divsqrt: RTL and testbench
==============================

EXP_DIVSQRT -- requirements
Module: exp_divsqrt

Interface
REQ-001 Parameter: none; formats fixed to double (bias 1023, max 2047) and single (bias 127, max 255).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  operand request; in_ready  out  1  block can accept.
REQ-005 op_sqrt  in  1  1=square root of A, 0=A/B.
REQ-006 fmt  in  1  1=double, 0=single (single uses exp_a[7:0], exp_b[7:0]; upper bits treated as 0).
REQ-007 exp_a, exp_b  in  11 each  biased input exponents.
REQ-008 abort  in  1  synchronous flush of in-flight operation.
REQ-009 mant_done  in  1  one-cycle pulse from the mantissa iteration path.
REQ-010 norm_shift  in  1  sampled with mant_done; 1 = mantissa result <1, exponent decrements.
REQ-011 odd_exp  out  1  unbiased A exponent odd (sqrt only); mantissa path pre-shifts.
REQ-012 out_valid  out  1; out_ready  in  1  result handshake.
REQ-013 exp_res  out  13  final exponent, two's complement.
REQ-014 ovf, unf  out  1 each  overflow / underflow flags, valid with out_valid.
REQ-015 busy  out  1  high in any state except IDLE.

Function
REQ-016 FSM states: IDLE, CALC, WAIT, ADJ, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE->CALC on in_valid&in_ready; operands, op_sqrt, fmt registered at that edge.
REQ-018 CALC (one cycle): 13-bit signed E computed and registered; div: E=A-B+bias (A+~B+1+bias, sign-extended operands); sqrt: u=A-bias, E=(u>>>1)+bias (arithmetic shift), odd_exp=u[0].
REQ-019 odd_exp valid from cycle after CALC until return to IDLE; 0 for divide and in IDLE.
REQ-020 mant_done sampled in CALC or WAIT; CALC->ADJ if sampled in CALC, else CALC->WAIT; WAIT holds until sampled; norm_shift captured same edge.
REQ-021 mant_done in IDLE, ADJ, DONE ignored.
REQ-022 ADJ (one cycle): exp_res=E-norm_shift; ovf=(exp_res signed >= max); unf=(exp_res signed <= 0); ->DONE.
REQ-023 DONE: out_valid=1; exp_res, ovf, unf held stable; DONE->IDLE on out_ready; out_valid clears next cycle.
REQ-024 Latency: mant_done pulsed in WAIT at cycle k -> out_valid high at cycle k+2.
REQ-025 All 13-bit arithmetic wraps modulo 2^13; no saturation of exp_res.
REQ-026 abort in any non-IDLE state -> IDLE next edge, out_valid=0, no result produced; abort has priority over out_ready and mant_done.
REQ-027 abort with in_valid in IDLE: request not accepted that cycle.
REQ-028 Back-to-back: in_valid during DONE not accepted; earliest new accept is cycle after DONE->IDLE.

Reset
REQ-029 reset asserted: state=IDLE; in_ready=1 after reset release; out_valid, busy, odd_exp, ovf, unf=0; exp_res=13'h0000.
REQ-030 reset mid-operation (any state) discards the operation; no out_valid pulse afterwards.

Verification
REQ-031 Double div A=1023, B=1023, mant_done in WAIT, norm_shift=0 -> exp_res=1023, ovf=0, unf=0, out_valid 2 cycles after mant_done.
REQ-032 Double div A=2046, B=1, norm_shift=0 -> exp_res=3068, ovf=1, unf=0.
REQ-033 Single div A=1, B=254, norm_shift=1 -> exp_res=13'h1F81 (-127), unf=1, ovf=0.
REQ-034 Double sqrt A=1026 -> odd_exp=1, exp_res=1024; A=1020 -> odd_exp=1, exp_res=1021; A=1024 -> odd_exp=1, exp_res=1023 (u=1); A=1025 -> odd_exp=0, exp_res=1024.
REQ-035 out_ready low 5 cycles in DONE while in_valid=1 -> exp_res/flags stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle, accept following cycle.
REQ-036 mant_done in CALC -> WAIT skipped; reset or abort asserted in WAIT -> IDLE, all outputs at reset values, later stray mant_done ignored.

Source files
------------

// File: rtl/exp_divsqrt_if.sv
// Request/result handshake bundle for the divide/sqrt exponent datapath.
interface exp_divsqrt_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_sqrt;
  logic        fmt;
  logic [10:0] exp_a;
  logic [10:0] exp_b;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] exp_res;
  logic        ovf;
  logic        unf;

  modport master (
    output in_valid, op_sqrt, fmt, exp_a, exp_b, out_ready,
    input  in_ready, out_valid, exp_res, ovf, unf
  );

  modport slave (
    input  in_valid, op_sqrt, fmt, exp_a, exp_b, out_ready,
    output in_ready, out_valid, exp_res, ovf, unf
  );
endinterface

// File: rtl/exp_divsqrt.sv
// Exponent path of a floating-point divide/square-root unit: computes the
// biased result exponent, applies the mantissa normalisation step, flags range.
module exp_divsqrt (
  input  logic           clk,
  input  logic           reset,
  exp_divsqrt_if.slave   io,
  input  logic           abort,
  input  logic           mant_done,
  input  logic           norm_shift,
  output logic           odd_exp,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, CALC, WAIT, ADJ, DONE} state_t;

  state_t        state;
  logic          sqrt_r;
  logic          fmt_r;
  logic [10:0]   a_r;
  logic [10:0]   b_r;
  logic [12:0]   e_r;
  logic          ns_r;

  logic [12:0]        a_eff;
  logic [12:0]        b_eff;
  logic [12:0]        bias13;
  logic [12:0]        max13;
  logic signed [12:0] u_s;
  logic [12:0]        e_calc;
  logic [12:0]        res_adj;

  // Single precision only looks at the low 8 exponent bits.
  always_comb begin
    a_eff   = fmt_r ? {2'b00, a_r} : {5'b00000, a_r[7:0]};
    b_eff   = fmt_r ? {2'b00, b_r} : {5'b00000, b_r[7:0]};
    bias13  = fmt_r ? 13'd1023 : 13'd127;
    max13   = fmt_r ? 13'd2047 : 13'd255;
    u_s     = $signed(a_eff - bias13);
    if (sqrt_r) e_calc = 13'(u_s >>> 1) + bias13;
    else        e_calc = a_eff + ~b_eff + 13'd1 + bias13;
    res_adj = e_r - {12'b0, ns_r};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sqrt_r       <= 1'b0;
      fmt_r        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      e_r          <= '0;
      ns_r         <= 1'b0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.exp_res   <= '0;
      io.ovf       <= 1'b0;
      io.unf       <= 1'b0;
      odd_exp      <= 1'b0;
      busy         <= 1'b0;
    end else if (abort && state != IDLE) begin
      state        <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.exp_res   <= '0;
      io.ovf       <= 1'b0;
      io.unf       <= 1'b0;
      odd_exp      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid && !abort) begin
          sqrt_r      <= io.op_sqrt;
          fmt_r       <= io.fmt;
          a_r         <= io.exp_a;
          b_r         <= io.exp_b;
          io.in_ready <= 1'b0;
          busy        <= 1'b1;
          state       <= CALC;
        end
        CALC: begin
          e_r     <= e_calc;
          odd_exp <= sqrt_r & u_s[0];
          if (mant_done) begin
            ns_r  <= norm_shift;
            state <= ADJ;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (mant_done) begin
          ns_r  <= norm_shift;
          state <= ADJ;
        end
        ADJ: begin
          io.exp_res   <= res_adj;
          io.ovf       <= $signed(res_adj) >= $signed(max13);
          io.unf       <= $signed(res_adj) <= 13'sd0;
          io.out_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: if (io.out_ready) begin
          io.out_valid <= 1'b0;
          io.in_ready  <= 1'b1;
          busy         <= 1'b0;
          odd_exp      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_divsqrt.sv
// Directed-vector bench for exp_divsqrt with hand-computed expected exponents.
module tb_exp_divsqrt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;
  logic mant_done = 1'b0;
  logic norm_shift = 1'b0;
  logic odd_exp;
  logic busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  exp_divsqrt_if bus();

  exp_divsqrt dut (
    .clk        (clk),
    .reset      (reset),
    .io         (bus),
    .abort      (abort),
    .mant_done  (mant_done),
    .norm_shift (norm_shift),
    .odd_exp    (odd_exp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and walk it to DONE, checking CALC/WAIT/ADJ on the way.
  task automatic to_done(input logic sq, input logic f, input logic [10:0] a,
                         input logic [10:0] b, input logic ns, input logic early,
                         input logic odd_exp_e, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_sqrt = sq; bus.fmt = f; bus.exp_a = a; bus.exp_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".calc_busy"}, busy, 1);
    chk({tag, ".calc_rdy"}, bus.in_ready, 0);
    if (early) begin
      mant_done = 1'b1; norm_shift = ns;
      @(negedge clk);
      mant_done = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, ".wait_odd"}, odd_exp, odd_exp_e);
      chk({tag, ".wait_ov"}, bus.out_valid, 0);
      mant_done = 1'b1; norm_shift = ns;
      @(negedge clk);
      mant_done = 1'b0;
    end
    chk({tag, ".adj_ov"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, ".out_valid"}, bus.out_valid, 1);
  endtask

  task automatic run_op(input logic sq, input logic f, input logic [10:0] a,
                        input logic [10:0] b, input logic ns, input logic early,
                        input logic [12:0] e_res, input logic e_ovf, input logic e_unf,
                        input logic e_odd, input string tag);
    to_done(sq, f, a, b, ns, early, e_odd, tag);
    chk({tag, ".exp_res"}, bus.exp_res, e_res);
    chk({tag, ".ovf"}, bus.ovf, e_ovf);
    chk({tag, ".unf"}, bus.unf, e_unf);
    chk({tag, ".odd"}, odd_exp, e_odd);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".idle_ov"}, bus.out_valid, 0);
    chk({tag, ".idle_rdy"}, bus.in_ready, 1);
    chk({tag, ".idle_odd"}, odd_exp, 0);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rdy"}, bus.in_ready, 1);
    chk({tag, ".ov"}, bus.out_valid, 0);
    chk({tag, ".odd"}, odd_exp, 0);
    chk({tag, ".res"}, bus.exp_res, 0);
    chk({tag, ".flags"}, {bus.ovf, bus.unf}, 0);
  endtask

  initial begin
    logic [12:0] held;
    bus.in_valid = 1'b0; bus.op_sqrt = 1'b0; bus.fmt = 1'b0;
    bus.exp_a = '0; bus.exp_b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_outputs("reset");

    run_op(0, 1, 11'd1023, 11'd1023, 0, 0, 13'd1023, 0, 0, 0, "dbl_div_one");
    run_op(0, 1, 11'd2046, 11'd1,    0, 0, 13'd3068, 1, 0, 0, "dbl_div_ovf");
    run_op(0, 0, 11'd1,    11'd254,  1, 0, 13'h1F81, 0, 1, 0, "sgl_div_unf");
    run_op(1, 1, 11'd1026, 11'd0,    0, 0, 13'd1024, 0, 0, 1, "sqrt_1026");
    run_op(1, 1, 11'd1020, 11'd0,    0, 0, 13'd1021, 0, 0, 1, "sqrt_1020");
    run_op(1, 1, 11'd1024, 11'd0,    0, 0, 13'd1023, 0, 0, 1, "sqrt_1024");
    run_op(1, 1, 11'd1025, 11'd0,    0, 0, 13'd1024, 0, 0, 0, "sqrt_1025");
    run_op(0, 1, 11'd1500, 11'd1000, 1, 1, 13'd1522, 0, 0, 0, "early_done");
    run_op(0, 0, 11'd200,  11'd72,   0, 0, 13'd255,  1, 0, 0, "sgl_ovf_edge");
    run_op(0, 1, 11'd1,    11'd1024, 0, 0, 13'd0,    0, 1, 0, "dbl_unf_zero");
    run_op(0, 0, 11'h70A,  11'h60A,  0, 0, 13'd127,  0, 0, 0, "sgl_mask");

    // Result held in DONE while a new request waits.
    to_done(0, 1, 11'd1100, 11'd1000, 0, 0, 0, "hold");
    held = bus.exp_res;
    chk("hold.value", held, 13'd1123);
    bus.in_valid = 1'b1; bus.op_sqrt = 1'b0; bus.fmt = 1'b1;
    bus.exp_a = 11'd1023; bus.exp_b = 11'd1023;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.res", bus.exp_res, held);
      chk("hold.ov", bus.out_valid, 1);
      chk("hold.rdy", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b.idle_rdy", bus.in_ready, 1);
    chk("b2b.idle_busy", busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b.accept", busy, 1);

    // Abort the accepted request in CALC.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_calc.busy", busy, 0);

    // Abort in WAIT clears outputs; a stray mant_done afterwards does nothing.
    to_done(1, 1, 11'd1026, 11'd0, 0, 1, 1, "pre");
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_sqrt = 1'b1; bus.exp_a = 11'd1026;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abw.odd_before", odd_exp, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle_outputs("abort_wait");
    mant_done = 1'b1;
    @(negedge clk);
    mant_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("abw.stray_ov", bus.out_valid, 0);
    chk("abw.stray_busy", busy, 0);

    // Asynchronous reset in WAIT.
    run_op(0, 1, 11'd1024, 11'd1000, 0, 0, 13'd1047, 0, 0, 0, "pre_rst");
    bus.in_valid = 1'b1; bus.op_sqrt = 1'b1; bus.exp_a = 11'd1020;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_async.busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_outputs("reset_wait");
    mant_done = 1'b1;
    @(negedge clk);
    mant_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw.stray_ov", bus.out_valid, 0);

    // Abort with in_valid in IDLE is not accepted.
    bus.in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle.busy", busy, 0);
    chk("abort_idle.rdy", bus.in_ready, 1);

    // Abort beats out_ready in DONE.
    to_done(0, 1, 11'd1023, 11'd1023, 0, 0, 0, "abd");
    abort = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.out_ready = 1'b0;
    idle_outputs("abort_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
